commit_trace_buffer: RTL and testbench

//  On-chip retirement trace: captures {pc, instr} of each committed instruction into a circular RAM.

---
 rtl/commit_trace_buffer_if.sv | 35 +++
 rtl/commit_trace_buffer.sv | 151 +++++++++++++++
 tb/tb_commit_trace_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// Commit and readback bus for the retirement trace buffer.
// Optional o_rd_ts when COMMIT_TRACE_TIMESTAMP_EN is defined.
interface commit_trace_buffer_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 3
);
  logic              i_commit_valid;
  logic [XLEN-1:0]   i_commit_pc;
  logic [XLEN-1:0]   i_commit_instr;
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_idx;
  logic              o_rd_valid;
  logic [2*XLEN-1:0] o_rd_data;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0]       o_rd_ts;
`endif

  modport slave (
    input  i_commit_valid, i_commit_pc, i_commit_instr,
    input  i_rd_en, i_rd_idx,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    output o_rd_ts,
`endif
    output o_rd_valid, o_rd_data
  );

  modport master (
    output i_commit_valid, i_commit_pc, i_commit_instr,
    output i_rd_en, i_rd_idx,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    input  o_rd_ts,
`endif
    input  o_rd_valid, o_rd_data
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular retirement trace with arm/trigger/post-count capture.
// COMMIT_TRACE_TIMESTAMP_EN adds a per-entry 32-bit cycle stamp.
module commit_trace_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int XLEN   = 32
) (
  input  logic                clk,
  input  logic                reset,
  commit_trace_buffer_if.slave bus,
  input  logic                i_arm,
  input  logic                i_trig_en,
  input  logic [XLEN-1:0]     i_trig_pc,
  input  logic                i_force_trig,
  input  logic [ADDR_W:0]     i_post_count,
  output logic [1:0]          o_state,
  output logic [ADDR_W:0]     o_count,
  output logic                o_wrapped,
  output logic [ADDR_W-1:0]   o_trig_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  localparam int W = 2*XLEN + 32;
`else
  localparam int W = 2*XLEN;
`endif

  localparam logic [ADDR_W:0]   LP_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_MAXP = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0]   LP_C1   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] LP_P1   = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_wrapped;
  logic [ADDR_W-1:0] r_trig_ptr;
  logic [ADDR_W:0]   r_post;
  logic              r_rd_valid;
  logic [2*XLEN-1:0] r_rd_data;
  logic [W-1:0]      r_ram [DEPTH];

  logic              w_write;
  logic              w_trig;
  logic [ADDR_W:0]   w_post;
  logic [ADDR_W-1:0] w_oldest;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_in_rng;
  logic [ADDR_W-1:0] w_last;
  logic [W-1:0]      w_word;
  logic [W-1:0]      w_rd_word;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_rd_ts;

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 32'd1;
  end

  assign w_word      = {r_ts, bus.i_commit_pc, bus.i_commit_instr};
  assign bus.o_rd_ts = r_rd_ts;
`else
  assign w_word = {bus.i_commit_pc, bus.i_commit_instr};
`endif

  assign w_write = bus.i_commit_valid & ~i_arm &
                   ((r_state == S_ARMED) | (r_state == S_POST));
  assign w_trig  = (r_state == S_ARMED) &
                   ((i_trig_en & bus.i_commit_valid &
                     (bus.i_commit_pc == i_trig_pc)) | i_force_trig);
  assign w_post    = (i_post_count > LP_MAXP) ? LP_MAXP : i_post_count;
  assign w_oldest  = r_wrapped ? r_wr_ptr : '0;
  assign w_rd_addr = w_oldest + bus.i_rd_idx;
  assign w_in_rng  = {1'b0, bus.i_rd_idx} < r_count;
  // Force without a commit pins the most recent entry
  assign w_last    = (r_count == '0) ? '0 : r_wr_ptr - LP_P1;
  assign w_rd_word = r_ram[w_rd_addr];

  always_ff @(posedge clk) begin
    if (!reset && w_write) r_ram[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_wrapped  <= 1'b0;
      r_trig_ptr <= '0;
      r_post     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      r_rd_ts    <= '0;
`endif
    end else begin
      if ((r_state == S_DONE) && bus.i_rd_en) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_in_rng ? w_rd_word[2*XLEN-1:0] : '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        r_rd_ts    <= w_in_rng ? w_rd_word[W-1 -: 32] : '0;
`endif
      end else begin
        r_rd_valid <= 1'b0;
      end

      if (i_arm) begin
        r_state   <= S_ARMED;
        r_wr_ptr  <= '0;
        r_count   <= '0;
        r_wrapped <= 1'b0;
      end else begin
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + LP_P1;
          if (r_count != LP_FULL) r_count <= r_count + LP_C1;
          if (r_wr_ptr == LP_LAST) r_wrapped <= 1'b1;
        end
        case (r_state)
          S_ARMED: if (w_trig) begin
            r_trig_ptr <= bus.i_commit_valid ? r_wr_ptr : w_last;
            r_post     <= w_post;
            r_state    <= (w_post == '0) ? S_DONE : S_POST;
          end
          S_POST: if (bus.i_commit_valid) begin
            r_post <= r_post - LP_C1;
            if (r_post == LP_C1) r_state <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_rd_data  = r_rd_data;
  assign o_state        = r_state;
  assign o_count        = r_count;
  assign o_wrapped      = r_wrapped;
  assign o_trig_idx     = r_trig_ptr - w_oldest;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer (DEPTH=8, XLEN=32).
// Timestamp checks compile in with COMMIT_TRACE_TIMESTAMP_EN.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_arm;
  logic        i_trig_en;
  logic [31:0] i_trig_pc;
  logic        i_force_trig;
  logic [3:0]  i_post_count;
  logic [1:0]  o_state;
  logic [3:0]  o_count;
  logic        o_wrapped;
  logic [2:0]  o_trig_idx;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [63:0] data;
    int          mode;
  } exp_t;

  exp_t exp_q[$];

  commit_trace_buffer_if #(.XLEN(32), .ADDR_W(3)) bus();

  commit_trace_buffer #(
    .DEPTH(8), .ADDR_W(3), .XLEN(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .i_arm        (i_arm),
    .i_trig_en    (i_trig_en),
    .i_trig_pc    (i_trig_pc),
    .i_force_trig (i_force_trig),
    .i_post_count (i_post_count),
    .o_state      (o_state),
    .o_count      (o_count),
    .o_wrapped    (o_wrapped),
    .o_trig_idx   (o_trig_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, ~pc};
  endfunction

  // mode: 0 data only, 1 ts must be 0, 2 ts = prev+3, 3 record ts
  logic [31:0] prev_ts = '0;

  always @(negedge clk) begin
    if (!reset && bus.o_rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rd: got %h want none", bus.o_rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", bus.o_rd_data, e.data);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        if (e.mode == 1) chk("rd_ts_zero", 64'(bus.o_rd_ts), 64'd0);
        if (e.mode == 2)
          chk("rd_ts_delta", 64'(bus.o_rd_ts - prev_ts), 64'd3);
        prev_ts = bus.o_rd_ts;
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic arm();
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic frc);
    bus.i_commit_valid = 1'b1;
    bus.i_commit_pc    = pc;
    bus.i_commit_instr = ~pc;
    i_force_trig       = frc;
    step();
    bus.i_commit_valid = 1'b0;
    i_force_trig       = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [63:0] d, input int m);
    exp_t e;
    e.data = d;
    e.mode = m;
    exp_q.push_back(e);
    bus.i_rd_en  = 1'b1;
    bus.i_rd_idx = idx[2:0];
    step();
    bus.i_rd_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset              = 1'b1;
    i_arm              = 1'b0;
    i_trig_en          = 1'b0;
    i_trig_pc          = '0;
    i_force_trig       = 1'b0;
    i_post_count       = '0;
    bus.i_commit_valid = 1'b0;
    bus.i_commit_pc    = '0;
    bus.i_commit_instr = '0;
    bus.i_rd_en        = 1'b0;
    bus.i_rd_idx       = '0;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_rdv", 64'(bus.o_rd_valid), 64'd0);
    chk("rst_wrap", 64'(o_wrapped), 64'd0);

    // pc-match trigger with two post-trigger commits
    commit(32'h0040_0000, 1'b0);
    chk("idle_ignores", 64'(o_count), 64'd0);
    i_trig_en    = 1'b1;
    i_trig_pc    = 32'h0040_0008;
    i_post_count = 4'd2;
    arm();
    chk("armed", 64'(o_state), 64'd1);
    for (int k = 0; k < 6; k++) begin
      commit(32'h0040_0000 + 32'(4*k), 1'b0);
      if (k == 3) chk("t1_post", 64'(o_state), 64'd2);
      if (k == 4) chk("t1_done", 64'(o_state), 64'd3);
    end
    chk("t1_count", 64'(o_count), 64'd5);
    chk("t1_trig", 64'(o_trig_idx), 64'd2);
    chk("t1_wrap", 64'(o_wrapped), 64'd0);
    rd(0, ent(32'h0040_0000), 0);
    rd(4, ent(32'h0040_0010), 0);
    rd(5, 64'd0, 0);

    // wrap-around, trigger on 12th commit, no post
    i_trig_pc    = 32'h0000_012C;
    i_post_count = 4'd0;
    arm();
    for (int k = 0; k < 12; k++) commit(32'h100 + 32'(4*k), 1'b0);
    chk("t2_done", 64'(o_state), 64'd3);
    chk("t2_wrap", 64'(o_wrapped), 64'd1);
    chk("t2_count", 64'(o_count), 64'd8);
    chk("t2_trig", 64'(o_trig_idx), 64'd7);
    rd(0, ent(32'h0000_0110), 0);
    rd(7, ent(32'h0000_012C), 0);

    // forced trigger, post clamped to DEPTH-1
    i_trig_en    = 1'b0;
    i_post_count = 4'd15;
    arm();
    commit(32'h200, 1'b1);
    for (int k = 1; k < 8; k++) begin
      commit(32'h200 + 32'(4*k), 1'b0);
      if (k == 6) chk("t3_post", 64'(o_state), 64'd2);
    end
    chk("t3_done", 64'(o_state), 64'd3);
    chk("t3_count", 64'(o_count), 64'd8);
    chk("t3_trig", 64'(o_trig_idx), 64'd0);
    rd(0, ent(32'h200), 0);
    rd(7, ent(32'h21C), 0);

    // re-arm during POST drops the same-cycle commit
    i_trig_en    = 1'b1;
    i_trig_pc    = 32'h300;
    i_post_count = 4'd3;
    arm();
    commit(32'h300, 1'b0);
    commit(32'h304, 1'b0);
    chk("t4_post", 64'(o_state), 64'd2);
    i_arm = 1'b1;
    commit(32'h308, 1'b0);
    i_arm = 1'b0;
    chk("t4_rearm", 64'(o_state), 64'd1);
    chk("t4_count", 64'(o_count), 64'd0);
    bus.i_rd_en = 1'b1;
    step();
    bus.i_rd_en = 1'b0;
    chk("t4_rd_off", 64'(bus.o_rd_valid), 64'd0);
    i_post_count = 4'd0;
    i_force_trig = 1'b1;
    step();
    i_force_trig = 1'b0;
    chk("t4_done", 64'(o_state), 64'd3);
    chk("t4_trig", 64'(o_trig_idx), 64'd0);
    rd(0, 64'd0, 0);

    // commits spaced three cycles apart, then out-of-range read
    i_trig_en = 1'b0;
    arm();
    commit(32'h500, 1'b0);
    repeat (2) step();
    commit(32'h504, 1'b0);
    commit(32'h508, 1'b0);
    commit(32'h50C, 1'b0);
    commit(32'h510, 1'b0);
    i_force_trig = 1'b1;
    step();
    i_force_trig = 1'b0;
    chk("t5_count", 64'(o_count), 64'd5);
    chk("t5_trig", 64'(o_trig_idx), 64'd4);
    rd(0, ent(32'h500), 3);
    rd(1, ent(32'h504), 2);
    rd(7, 64'd0, 1);

    repeat (2) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
